// File: rtl/sram_2p_scrub.sv
// Simple-dual-port SRAM with per-lane write enables, a registered read port and
// a sequential scrub engine that zeroes the array after reset or on request.
// The array itself has no reset so it can map onto block RAM.
module sram_2p_scrub #(
  parameter int unsigned LANE_W  = 9,
  parameter int unsigned LANES   = 8,
  parameter int unsigned AW      = 5,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned WR_MODE = 0
) (
  input  logic                    clka,
  input  logic                    rst,
  input  logic                    wen,
  input  logic [AW-1:0]           waddr,
  input  logic [LANES-1:0]        wbe,
  input  logic [LANE_W*LANES-1:0] wdata,
  input  logic                    ren,
  input  logic [AW-1:0]           raddr,
  output logic [LANE_W*LANES-1:0] rdata,
  output logic                    rvalid,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam int unsigned DW = LANE_W * LANES;
  localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StScrub, StIdle} state_e;

  state_e          state;
  logic [AW-1:0]   ptr;
  logic [DW-1:0]   mem [DEPTH];

  logic            waddr_ok;
  logic            raddr_ok;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [LANES-1:0] mem_wbe;
  logic [DW-1:0]   mem_wd;
  logic [DW-1:0]   rd_word;

  assign waddr_ok = 32'(waddr) < DEPTH;
  assign raddr_ok = 32'(raddr) < DEPTH;

  // Single physical write port shared by the scrub engine and user writes.
  always_comb begin
    mem_we  = 1'b0;
    mem_wa  = waddr;
    mem_wbe = wbe;
    mem_wd  = wdata;
    if (state == StScrub) begin
      mem_we  = 1'b1;
      mem_wa  = ptr;
      mem_wbe = '1;
      mem_wd  = '0;
    end else if (wen && waddr_ok) begin
      mem_we = 1'b1;
    end
  end

  // Array storage: lane-masked write, no reset.
  always_ff @(posedge clka) begin
    if (mem_we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (mem_wbe[i]) begin
          mem[mem_wa][i*LANE_W +: LANE_W] <= mem_wd[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read word, with write-first bypass of enabled lanes on an address collision.
  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      rd_word = mem[raddr];
      if ((WR_MODE == 0) && wen && (waddr == raddr)) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (wbe[i]) begin
            rd_word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  // Control FSM: scrub sequencing, busy flag and registered read port.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state  <= StScrub;
      ptr    <= '0;
      busy   <= 1'b1;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      unique case (state)
        StScrub: begin
          rvalid <= 1'b0;
          if (ptr == LastPtr) begin
            state <= StIdle;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        StIdle: begin
          rvalid <= ren;
          if (ren) begin
            rdata <= rd_word;
          end
          // Accesses in this cycle are still honoured; scrub starts next cycle.
          if (clr_req) begin
            state <= StScrub;
            busy  <= 1'b1;
            ptr   <= '0;
          end
        end
        default: begin
          state <= StScrub;
          busy  <= 1'b1;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_2p_scrub.sv
// Directed bench for sram_2p_scrub: three instances share stimulus
// (u0 default, u1 read-first, u2 DEPTH=20).
module tb_sram_2p_scrub;

  localparam int DW = 72;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic [4:0]    waddr = '0;
  logic [7:0]    wbe = '0;
  logic [DW-1:0] wdata = '0;
  logic          ren = 1'b0;
  logic [4:0]    raddr = '0;
  logic          clr_req = 1'b0;

  logic [DW-1:0] rdata0, rdata1, rdata2;
  logic          rvalid0, rvalid1, rvalid2;
  logic          busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_2p_scrub #(.DEPTH(32), .WR_MODE(0)) u0 (
    .clka(clk), .rst(rst), .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .clr_req(clr_req),
    .busy(busy0)
  );

  sram_2p_scrub #(.DEPTH(32), .WR_MODE(1)) u1 (
    .clka(clk), .rst(rst), .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .clr_req(clr_req),
    .busy(busy1)
  );

  sram_2p_scrub #(.DEPTH(20), .WR_MODE(0)) u2 (
    .clka(clk), .rst(rst), .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2), .clr_req(clr_req),
    .busy(busy2)
  );

  // Count busy samples over a fixed window starting at the current negedge.
  task automatic count_busy(input string tag, input bit poke);
    int c0 = 0, c1 = 0, c2 = 0;
    bit stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (busy2) c2++;
      if (rvalid0 || rvalid1 || rvalid2) stray = 1'b1;
      // Accesses while every instance is still scrubbing must be ignored.
      wen   = poke && (i < 19);
      ren   = poke && (i < 19);
      waddr = 5'd4;
      raddr = 5'd4;
      wbe   = 8'hFF;
      wdata = '1;
      @(negedge clk);
    end
    wen = 1'b0;
    ren = 1'b0;
    checks++;
    if (c0 !== 32 || c1 !== 32 || c2 !== 20) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d/%0d/%0d want 32/32/20", tag, c0, c1, c2);
    end
    checks++;
    if (stray || busy0 || busy2) begin
      errors++;
      $display("FAIL %s rvalid during scrub or busy stuck: stray=%0b busy=%0b%0b",
               tag, stray, busy0, busy2);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] be, input logic [DW-1:0] d);
    wen = 1'b1; waddr = a; wbe = be; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    ren = 1'b1; raddr = a;
    @(negedge clk);
    ren = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #3;
    checks++;
    if (rdata0 !== '0 || rvalid0 !== 1'b0 || busy0 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL reset: rdata=%h rvalid=%b busy=%b%b want 0/0/11",
               rdata0, rvalid0, busy0, busy2);
    end
    @(negedge clk);
    rst = 1'b1;
    count_busy("reset_scrub", 1'b0);
  endtask

  task automatic test_read_zero();
    bit bad = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ren = 1'b1; raddr = 5'(a);
      @(negedge clk);
      if (rvalid0 !== 1'b1 || rdata0 !== '0 || rvalid2 !== 1'b1 || rdata2 !== '0) bad = 1'b1;
    end
    ren = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL read_zero: last rdata=%h rvalid=%b want 0/1", rdata0, rvalid0);
    end
  endtask

  task automatic test_full_write();
    logic [DW-1:0] exp = 72'h123456789ABCDEF012;
    do_write(5'd5, 8'hFF, exp);
    do_read(5'd5);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== exp) begin
      errors++;
      $display("FAIL full_write: rdata=%h rvalid=%b want %h/1", rdata0, rvalid0, exp);
    end
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== exp) begin
      errors++;
      $display("FAIL read_hold: rdata=%h rvalid=%b want %h/0", rdata0, rvalid0, exp);
    end
  endtask

  task automatic test_lane_mask();
    logic [DW-1:0] exp = {36'hFFFFFFFFF, 36'h0};
    do_write(5'd7, 8'hFF, '1);
    do_write(5'd7, 8'h0F, '0);
    do_write(5'd7, 8'h00, 72'h5);
    do_read(5'd7);
    checks++;
    if (rdata0 !== exp) begin
      errors++;
      $display("FAIL lane_mask: rdata=%h want %h", rdata0, exp);
    end
  endtask

  task automatic test_collision();
    wen = 1'b1; waddr = 5'd3; wbe = 8'hFF; wdata = 72'hAB;
    ren = 1'b1; raddr = 5'd3;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    checks++;
    if (rdata0 !== 72'hAB || rdata1 !== 72'h0 || !rvalid0 || !rvalid1) begin
      errors++;
      $display("FAIL collision_full: wf=%h rf=%h want ab/0", rdata0, rdata1);
    end
    do_read(5'd3);
    checks++;
    if (rdata0 !== 72'hAB || rdata1 !== 72'hAB) begin
      errors++;
      $display("FAIL collision_after: wf=%h rf=%h want ab/ab", rdata0, rdata1);
    end
    // Partial collision: only lane 1 written.
    wen = 1'b1; waddr = 5'd3; wbe = 8'h02; wdata = '1;
    ren = 1'b1; raddr = 5'd3;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    checks++;
    if (rdata0 !== 72'h3FEAB || rdata1 !== 72'hAB) begin
      errors++;
      $display("FAIL collision_lane: wf=%h rf=%h want 3feab/ab", rdata0, rdata1);
    end
  endtask

  task automatic test_back_to_back();
    do_write(5'd10, 8'hFF, 72'h111);
    do_write(5'd11, 8'hFF, 72'h222);
    ren = 1'b1; raddr = 5'd10;
    @(negedge clk);
    checks++;
    if (rdata0 !== 72'h111 || !rvalid0) begin
      errors++;
      $display("FAIL b2b_first: rdata=%h want 111", rdata0);
    end
    raddr = 5'd11;
    @(negedge clk);
    ren = 1'b0;
    checks++;
    if (rdata0 !== 72'h222 || !rvalid0) begin
      errors++;
      $display("FAIL b2b_second: rdata=%h want 222", rdata0);
    end
  endtask

  task automatic test_clear();
    bit bad = 1'b0;
    for (int a = 0; a < 32; a++) do_write(5'(a), 8'hFF, DW'(a + 1));
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    count_busy("clear_scrub", 1'b1);
    for (int a = 0; a < 32; a++) begin
      ren = 1'b1; raddr = 5'(a);
      @(negedge clk);
      if (rdata0 !== '0 || rdata1 !== '0 || rdata2 !== '0 || !rvalid0) bad = 1'b1;
    end
    ren = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL clear_contents: last rdata=%h want 0", rdata0);
    end
    // Reset partway through a scrub restarts the full sweep.
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== '0) begin
      errors++;
      $display("FAIL midscrub_reset: busy=%b rvalid=%b rdata=%h want 1/0/0",
               busy0, rvalid0, rdata0);
    end
    rst = 1'b1;
    count_busy("midscrub_restart", 1'b0);
  endtask

  task automatic test_depth_bound();
    do_write(5'd25, 8'hFF, 72'hDEAD);
    do_read(5'd25);
    checks++;
    if (rdata2 !== '0 || rvalid2 !== 1'b1) begin
      errors++;
      $display("FAIL oob_read: rdata=%h rvalid=%b want 0/1", rdata2, rvalid2);
    end
    checks++;
    if (rdata0 !== 72'hDEAD) begin
      errors++;
      $display("FAIL inbound_32: rdata=%h want dead", rdata0);
    end
    do_read(5'd5);
    checks++;
    if (rdata2 !== '0) begin
      errors++;
      $display("FAIL oob_alias: rdata=%h want 0", rdata2);
    end
    do_write(5'd19, 8'hFF, 72'hBEEF);
    do_read(5'd19);
    checks++;
    if (rdata2 !== 72'hBEEF || rvalid2 !== 1'b1) begin
      errors++;
      $display("FAIL last_addr: rdata=%h rvalid=%b want beef/1", rdata2, rvalid2);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_full_write();
    test_lane_mask();
    test_collision();
    test_back_to_back();
    test_clear();
    test_depth_bound();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
